sn74_mux_scan: RTL
==================

Name: sn74_mux_scan

Overview:
Parametrised successor to the quad 2-to-1 data selector with strobe. It is an N-channel, W-bit selector with a registered output and optional inverting output polarity. It also has an auto-scan mode that sequences through the channels with a programmable dwell time. It sits in the sn74 library as a clocked general-purpose selector, used for display multiplexing and bus sampling.

Parameters:
WIDTH, 4, bit width of each data channel and of out
CHANNELS, 4, number of input channels (2..16, need not be a power of two)
DWELL, 1, clock cycles spent on each channel in scan mode (>=1)
INVERT, 1, 1 = out carries inverted data (158-style), 0 = true data
SEL_W, derived localparam = max(1, clog2(CHANNELS)), not user-set

Ports:
clk    input   1                 clock, rising edge
rst_n  input   1                 asynchronous active-low reset
din    input   CHANNELS*WIDTH    packed channel data; channel k at din[k*WIDTH +: WIDTH]
sel    input   SEL_W             channel select in manual mode; scan start channel
str    input   1                 strobe, active high = output disabled
mode   input   1                 0 = manual, 1 = scan
load   input   1                 manual-mode capture enable
out    output  WIDTH             registered selected data
ch     output  SEL_W             channel currently selected, registered
valid  output  1                 one-cycle pulse: out holds the first sample of a new channel
err    output  1                 registered: last selection was out of range

Behaviour:
- Reset (async, rst_n=0):
  - out = DIS, where DIS = INVERT ? all ones : all zeros.
  - ch = 0, dwell counter dcnt = 0, valid = 0, err = 0.
  - Outputs take these values immediately; the first update is on the first rising edge after release.
- Data function: f(x) = INVERT ? ~x : x.
- str=1 (any mode):
  - out <= DIS, valid <= 0.
  - ch and dcnt frozen.
  - err holds its value.
  - str takes priority over load and scan.
- Manual mode (mode=0, str=0):
  - ch <= sel every cycle.
  - load=1: out <= f(din[sel]); latency 1 cycle.
  - load=0: out holds.
  - valid <= load & (sel != ch).
  - dcnt held at 0.
- Scan mode (mode=1, str=0):
  - out <= f(din[ch]) every cycle; load is ignored.
  - Sequencer states: ENTER, DWELL.
  - ENTER is the first cycle after mode rises 0->1: ch <= sel, dcnt <= 0, valid <= 0.
  - DWELL:
    - If dcnt == DWELL-1: dcnt <= 0 and ch <= (ch == CHANNELS-1) ? 0 : ch+1.
    - Otherwise dcnt <= dcnt+1.
    - valid <= (dcnt == 0), i.e. pulses once per channel visit.
  - Wrap: CHANNELS-1 -> 0, including for non-power-of-two CHANNELS.
- Mode change scan -> manual: takes effect next edge; ch follows sel; any pending dwell is discarded.
- Out-of-range select (sel >= CHANNELS, or ch >= CHANNELS):
  - out <= DIS, err <= 1.
  - In scan mode the ENTER cycle clamps ch to 0 instead.
  - err clears on the next in-range selection.
- DWELL=1: ch advances every cycle and valid stays high continuously.
- Simultaneous str fall and mode rise: ENTER is taken on that edge.

Optional Feature:
SN74_MUX_SCAN_PARITY_EN
- Defined: adds output par (1 bit), registered in the same cycle as out, equal to the even parity (XOR reduction) of the next value of out. It resets to XOR of DIS.
- Not defined: port par is absent, no parity logic.

Decomposition:
- Package sn74_mux_pkg holds:
  - Sequencer state encoding (ENTER, DWELL).
  - Function dis_val(WIDTH, INVERT).
  - Function clog2.
- One sub-module, sn74_mux_scan_seq: owns ch, dcnt, state, wrap and valid generation.
- The top level holds the data path, strobe, out register and err.

Test Plan:
- Common settings: WIDTH=4, CHANNELS=4, INVERT=1, din = {ch3=0000, ch2=0011, ch1=1111, ch0=1010}.
- Reset: rst_n=0 mid-cycle -> out=1111, ch=0, valid=0 immediately, without waiting for clk.
- Manual: mode=0, str=0, load=1, sel=1 -> next edge out=0000, ch=1, valid=1. Then sel=1, load=0 -> out holds, valid=0.
- Strobe: str=1 with load=1, sel=0 -> out=1111, ch frozen. str=0 -> next edge out=0101.
- Scan, DWELL=2, sel=2, mode 0->1:
  - ch goes 2,2,2(ENTER),3,3,0,0,1,1,2.
  - out reaches 1100, 1111, 0101, 0000.
  - valid pulses once per channel.
  - Reset mid-scan returns ch to 0 and out to 1111.
- CHANNELS=3, manual, sel=3, load=1 -> out=1111, err=1. Then sel=0 -> out=0101, err=0. In scan mode the wrap goes 2->0.
- With SN74_MUX_SCAN_PARITY_EN: out=0101 -> par=0; out=1000 -> par=1; after reset par=0 (XOR of 1111).

Source files
------------

// File: rtl/sn74_mux_pkg.sv
// Shared types and helpers for the sn74_mux_scan selector family.
package sn74_mux_pkg;

  typedef enum logic [0:0] {
    ST_ENTER = 1'b0,
    ST_DWELL = 1'b1
  } seq_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Disabled-output pattern: all ones for the inverting variant, else all zeros.
  function automatic logic [63:0] dis_val(input int unsigned width, input int unsigned invert);
    logic [63:0] m;
    m = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (invert != 0) ? m : '0;
  endfunction

endpackage

// File: rtl/sn74_mux_scan_seq.sv
// Channel sequencer for sn74_mux_scan: owns ch, the dwell counter, the
// ENTER/DWELL state, wrap-around and the valid pulse.
module sn74_mux_scan_seq
  import sn74_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 1,
  parameter int unsigned SEL_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_str,
  input  logic             i_mode,
  input  logic             i_load,
  input  logic [SEL_W-1:0] i_sel,
  output logic [SEL_W-1:0] o_ch,
  output logic             o_valid
);

  localparam int unsigned       DCNT_W    = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [SEL_W-1:0]  LAST_CH   = SEL_W'(CHANNELS - 1);
  localparam logic [DCNT_W-1:0] LAST_DCNT = DCNT_W'(DWELL - 1);

  seq_state_e        r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_ch, w_ch_nxt;
  logic [DCNT_W-1:0] r_dcnt, w_dcnt_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_sel_oor;

  assign w_sel_oor = (32'(i_sel) >= CHANNELS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ENTER;
      r_ch    <= '0;
      r_dcnt  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Manual edges park the FSM in ENTER, so the first unstrobed scan edge
  // (including one coinciding with a strobe release) is always the ENTER edge.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_str) w_state_nxt = i_mode ? ST_DWELL : ST_ENTER;
  end

  always_comb begin
    w_ch_nxt    = r_ch;
    w_dcnt_nxt  = r_dcnt;
    w_valid_nxt = 1'b0;
    if (!i_str) begin
      if (!i_mode) begin
        w_ch_nxt    = i_sel;
        w_dcnt_nxt  = '0;
        w_valid_nxt = i_load && (i_sel != r_ch);
      end else if (r_state == ST_ENTER) begin
        w_ch_nxt   = w_sel_oor ? '0 : i_sel;
        w_dcnt_nxt = '0;
      end else begin
        w_valid_nxt = (r_dcnt == '0);
        if (r_dcnt == LAST_DCNT) begin
          w_dcnt_nxt = '0;
          w_ch_nxt   = (r_ch >= LAST_CH) ? '0 : r_ch + SEL_W'(1);
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_W'(1);
        end
      end
    end
  end

  assign o_ch    = r_ch;
  assign o_valid = r_valid;

endmodule

// File: rtl/sn74_mux_scan.sv
// N-channel W-bit registered selector with strobe, optional inversion and auto-scan.
// Optional parity output enabled by defining SN74_MUX_SCAN_PARITY_EN.
module sn74_mux_scan
  import sn74_mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 4,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DWELL    = 1,
  parameter  int unsigned INVERT   = 1,
  localparam int unsigned SEL_W    = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      str,
  input  logic                      mode,
  input  logic                      load,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      err
`ifdef SN74_MUX_SCAN_PARITY_EN
  ,
  output logic                      par
`endif
);

  localparam logic [WIDTH-1:0] DIS = WIDTH'(dis_val(WIDTH, INVERT));

  logic [SEL_W-1:0] w_ch, w_idx;
  logic             w_oor;
  logic [WIDTH-1:0] w_data, w_fdata, w_out_nxt, r_out;
  logic             w_err_nxt, r_err;

  sn74_mux_scan_seq #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL),
    .SEL_W    (SEL_W)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_str   (str),
    .i_mode  (mode),
    .i_load  (load),
    .i_sel   (sel),
    .o_ch    (w_ch),
    .o_valid (valid)
  );

  assign w_idx = mode ? w_ch : sel;
  assign w_oor = (32'(w_idx) >= CHANNELS);

  // Explicit compare-mux keeps out-of-range indices from reading past din.
  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(w_idx) == k) w_data = din[k*WIDTH +: WIDTH];
    end
  end

  assign w_fdata = (INVERT != 0) ? ~w_data : w_data;

  always_comb begin
    w_out_nxt = r_out;
    w_err_nxt = r_err;
    if (str) begin
      w_out_nxt = DIS;
    end else if (mode) begin
      w_out_nxt = w_oor ? DIS : w_fdata;
      w_err_nxt = w_oor;
    end else begin
      w_err_nxt = w_oor;
      if (load) w_out_nxt = w_oor ? DIS : w_fdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= DIS;
      r_err <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      r_err <= w_err_nxt;
    end
  end

`ifdef SN74_MUX_SCAN_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par <= ^DIS;
    else        r_par <= ^w_out_nxt;
  end

  assign par = r_par;
`endif

  assign out = r_out;
  assign ch  = w_ch;
  assign err = r_err;

endmodule
